// File: rtl/writeback_arbiter.sv
// writeback_arbiter: single register-file write port fed by the ALU (priority) and a shared in-order load/muldiv FIFO.
// Define WB_PERF_EN to add o_blocked_cycles, counting cycles the ALU holds off a non-empty FIFO.
module writeback_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic [4:0]      i_ld_rd,
  input  logic [XLEN-1:0] i_ld_data,
  input  logic            i_md_valid,
  output logic            o_md_ready,
  input  logic [4:0]      i_md_rd,
  input  logic [XLEN-1:0] i_md_data,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_rd_data,
  output logic [31:0]     o_pending,
  output logic            o_fifo_full
`ifdef WB_PERF_EN
  ,
  output logic [31:0]     o_blocked_cycles
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      rd_mem_q [FIFO_DEPTH];
  logic [4:0]      rd_mem_d [FIFO_DEPTH];
  logic [XLEN-1:0] data_mem_q [FIFO_DEPTH];
  logic [XLEN-1:0] data_mem_d [FIFO_DEPTH];
  logic            rr_q, rr_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            full, empty, ld_fire, md_fire, push, pop;
  logic [4:0]      push_rd;
  logic [XLEN-1:0] push_data;
  // rr_q=0 favours load when both sources offer in the same cycle
  assign full       = cnt_q == CW'(FIFO_DEPTH);
  assign empty      = cnt_q == '0;
  assign o_ld_ready = !full && (!i_md_valid || !rr_q);
  assign o_md_ready = !full && (!i_ld_valid || rr_q);
  assign ld_fire    = i_ld_valid && o_ld_ready;
  assign md_fire    = i_md_valid && o_md_ready;
  assign push_rd    = ld_fire ? i_ld_rd : i_md_rd;
  assign push_data  = ld_fire ? i_ld_data : i_md_data;
  assign push       = (ld_fire || md_fire) && push_rd != 5'd0;
  assign pop        = !empty && !i_alu_valid;
  assign o_rd        = out_rd_q;
  assign o_rd_data   = out_data_q;
  assign o_fifo_full = full;
  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      rd_mem_d[wr_ptr_q]   = push_rd;
      data_mem_d[wr_ptr_q] = push_data;
    end
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    rr_d       = (i_ld_valid && i_md_valid && (ld_fire || md_fire)) ? !rr_q : rr_q;
    out_rd_d   = i_alu_valid ? i_alu_rd : pop ? rd_mem_q[rd_ptr_q] : 5'd0;
    out_data_d = i_alu_valid ? i_alu_data : pop ? data_mem_q[rd_ptr_q] : out_data_q;
  end
  always_comb begin
    o_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (CW'(i) < cnt_q) o_pending[rd_mem_q[rd_ptr_q + PW'(i)]] = 1'b1;
    o_pending[0] = 1'b0;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      out_rd_q   <= '0;
      out_data_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      out_rd_q   <= out_rd_d;
      out_data_q <= out_data_d;
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
    end
  end
`ifdef WB_PERF_EN
  logic [31:0] blocked_q, blocked_d;
  assign blocked_d        = blocked_q + 32'(!empty && i_alu_valid);
  assign o_blocked_cycles = blocked_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) blocked_q <= '0;
    else blocked_q <= blocked_d;
  end
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed and random stimulus against a queue-based writeback model with a scoreboard monitor.
module tb_writeback_arbiter;
  localparam int DEPTH = 4;
  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wr_t;
  logic        i_clk = 1'b0, i_reset = 1'b1;
  logic        i_alu_valid = 1'b0, i_ld_valid = 1'b0, i_md_valid = 1'b0;
  logic [4:0]  i_alu_rd = '0, i_ld_rd = '0, i_md_rd = '0;
  logic [31:0] i_alu_data = '0, i_ld_data = '0, i_md_data = '0;
  logic        o_ld_ready, o_md_ready, o_fifo_full;
  logic [4:0]  o_rd;
  logic [31:0] o_rd_data, o_pending;
`ifdef WB_PERF_EN
  logic [31:0] o_blocked_cycles;
`endif
  wr_t mq[$];
  wr_t sb[$];
  bit  fav_ld = 1'b1;
  int  vectors = 0, miscompares = 0;
  writeback_arbiter #(.FIFO_DEPTH(DEPTH), .XLEN(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
    .i_md_valid(i_md_valid), .o_md_ready(o_md_ready), .i_md_rd(i_md_rd), .i_md_data(i_md_data),
    .o_rd(o_rd), .o_rd_data(o_rd_data), .o_pending(o_pending), .o_fifo_full(o_fifo_full)
`ifdef WB_PERF_EN
    , .o_blocked_cycles(o_blocked_cycles)
`endif
  );
  always #5 i_clk = ~i_clk;
  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] pend_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    return m;
  endfunction
  // one clock: drive inputs after the edge, check ready/full/pending, then advance the model across the next edge
  task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                      input bit lv, input logic [4:0] lr, input logic [31:0] ldd,
                      input bit mv, input logic [4:0] mr, input logic [31:0] mdd,
                      output bit lf, output bit mf);
    bit full_e, lr_e, mr_e;
    @(posedge i_clk);
    #1;
    i_alu_valid = av; i_alu_rd = ar; i_alu_data = ad;
    i_ld_valid = lv; i_ld_rd = lr; i_ld_data = ldd;
    i_md_valid = mv; i_md_rd = mr; i_md_data = mdd;
    #1;
    full_e = mq.size() == DEPTH;
    lr_e = !full_e && (!mv || fav_ld);
    mr_e = !full_e && (!lv || !fav_ld);
    chk("ld_ready", o_ld_ready, lr_e);
    chk("md_ready", o_md_ready, mr_e);
    chk("fifo_full", o_fifo_full, full_e);
    chk("pending", o_pending, pend_mask());
    if (av) begin
      if (ar != 0) sb.push_back('{ar, ad});
    end else if (mq.size() > 0) sb.push_back(mq.pop_front());
    lf = lv && lr_e;
    mf = mv && mr_e;
    if (lf && lr != 0) mq.push_back('{lr, ldd});
    if (mf && mr != 0) mq.push_back('{mr, mdd});
    if (lv && mv && (lf || mf)) fav_ld = !fav_ld;
  endtask
  task automatic idle(output bit lf, output bit mf);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, lf, mf);
  endtask
  // asynchronous reset asserted between edges, then released with idle inputs
  task automatic do_reset();
    #1;
    i_reset = 1'b1;
    i_alu_valid = 0; i_ld_valid = 0; i_md_valid = 0;
    mq.delete(); sb.delete(); fav_ld = 1'b1;
    #1;
    chk("reset_rd", o_rd, 0);
    chk("reset_pending", o_pending, 0);
    chk("reset_full", o_fifo_full, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask
  always @(negedge i_clk) begin
    wr_t e;
    if (!i_reset && o_rd != 0) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL wb_unexpected: got rd=%0d data=%0h expected no write", o_rd, o_rd_data);
      end else begin
        e = sb.pop_front();
        chk("wb_rd", o_rd, e.rd);
        chk("wb_data", o_rd_data, e.data);
      end
    end
  end
  function automatic logic [4:0] rnd_rd();
    return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction
  initial begin
    bit lf, mf, lv, mv, av;
    logic [4:0] lr, mr;
    logic [31:0] ldd, mdd;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    // reset with three entries queued
    for (int k = 1; k <= 3; k++) step(1, 9, 32'h900 + k, 1, 5'(k), 32'h100 + k, 0, 0, 0, lf, mf);
    step(1, 9, 32'h904, 0, 0, 0, 0, 0, 0, lf, mf);
    chk("pending_three", o_pending, 32'h0000_000e);
    do_reset();
    step(0, 0, 0, 1, 6, 32'h66, 0, 0, 0, lf, mf);
    chk("ld_ready_after_reset", o_ld_ready, 1);
    idle(lf, mf);
    idle(lf, mf);
    chk("rd_after_reset_load", o_rd, 6);
    // ALU only
    do_reset();
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, lf, mf);
    idle(lf, mf);
    chk("alu_rd", o_rd, 5);
    chk("alu_data", o_rd_data, 32'hDEADBEEF);
    idle(lf, mf);
    chk("alu_then_idle", o_rd, 0);
    chk("idle_data_hold", o_rd_data, 32'hDEADBEEF);
    // load held off by three ALU cycles
    step(1, 9, 32'hA1, 1, 7, 32'h11, 0, 0, 0, lf, mf);
    chk("ld7_accept", lf, 1);
    step(1, 9, 32'hA2, 0, 0, 0, 0, 0, 0, lf, mf);
    chk("pend7_a", o_pending[7], 1);
    step(1, 9, 32'hA3, 0, 0, 0, 0, 0, 0, lf, mf);
    chk("pend7_b", o_pending[7], 1);
    idle(lf, mf);
    chk("pend7_c", o_pending[7], 1);
    idle(lf, mf);
    chk("ld7_rd", o_rd, 7);
    chk("ld7_data", o_rd_data, 32'h11);
    chk("pend7_clear", o_pending[7], 0);
    // simultaneous load and muldiv from reset
    do_reset();
    step(0, 0, 0, 1, 3, 32'h33, 1, 4, 32'h44, lf, mf);
    chk("both_ld_first", {lf, mf}, 2'b10);
    step(0, 0, 0, 0, 0, 0, 1, 4, 32'h44, lf, mf);
    chk("md_second", mf, 1);
    chk("seq_none_yet", o_rd, 0);
    idle(lf, mf);
    chk("seq_first", o_rd, 3);
    idle(lf, mf);
    chk("seq_second", o_rd, 4);
    // fill to full behind a continuous ALU stream
    do_reset();
    for (int k = 1; k <= 4; k++) step(1, 9, 32'hB00 + k, 1, 5'(k + 10), 32'hC00 + k, 0, 0, 0, lf, mf);
    step(1, 9, 32'hB05, 1, 15, 32'hC05, 0, 0, 0, lf, mf);
    chk("full_set", o_fifo_full, 1);
    chk("full_no_ready", o_ld_ready, 0);
    step(0, 0, 0, 1, 15, 32'hC05, 0, 0, 0, lf, mf);
    chk("full_pop_cycle_no_accept", lf, 0);
    step(1, 9, 32'hB06, 1, 15, 32'hC05, 0, 0, 0, lf, mf);
    chk("full_drop", o_fifo_full, 0);
    chk("ready_back", o_ld_ready, 1);
    repeat (8) idle(lf, mf);
    // rd=0 load is accepted but never queued
    do_reset();
    step(0, 0, 0, 1, 0, 32'hABCD, 0, 0, 0, lf, mf);
    chk("rd0_accept", lf, 1);
    idle(lf, mf);
    chk("rd0_pending", o_pending, 0);
    chk("rd0_full", o_fifo_full, 0);
    idle(lf, mf);
    chk("rd0_no_write", o_rd, 0);
    // random traffic, light then heavy ALU load
    lv = 0; mv = 0; lr = 0; mr = 0; ldd = 0; mdd = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!lv && $urandom_range(0, 2) == 0) begin lv = 1; lr = rnd_rd(); ldd = $urandom; end
      if (!mv && $urandom_range(0, 2) == 0) begin mv = 1; mr = rnd_rd(); mdd = $urandom; end
      av = $urandom_range(0, 99) < ((c < 1000) ? 40 : 85);
      step(av, rnd_rd(), $urandom, lv, lr, ldd, mv, mr, mdd, lf, mf);
      if (lf) lv = 0;
      if (mf) mv = 0;
    end
    repeat (12) idle(lf, mf);
    @(negedge i_clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage that produces the register file's single write port (rd index plus write data) from three result sources:
  - single-cycle ALU: fixed priority, never stalled;
  - load unit: valid/ready handshake;
  - multi-cycle mul/div unit: valid/ready handshake.
- Load and mul/div results are buffered in a shared in-order FIFO and drained whenever the ALU leaves the write port idle.
- Exports a pending-destination mask so the hazard unit can stall readers of registers still waiting for writeback.

Parameters:
- FIFO_DEPTH, 4, entries in the shared load/muldiv pending FIFO; power of two, minimum 2.
- XLEN, rapid_pkg::XLEN, data width.

Ports:
- i_clk  input  1  core clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_alu_valid  input  1  ALU result present this cycle.
- i_alu_rd  input  5  ALU destination register.
- i_alu_data  input  XLEN  ALU result.
- i_ld_valid  input  1  load result offered.
- o_ld_ready  output  1  load result accepted when valid & ready.
- i_ld_rd  input  5  load destination.
- i_ld_data  input  XLEN  load data.
- i_md_valid  input  1  mul/div result offered.
- o_md_ready  output  1  mul/div result accepted when valid & ready.
- i_md_rd  input  5  mul/div destination.
- i_md_data  input  XLEN  mul/div result.
- o_rd  output  5  register file write index; 0 means no write.
- o_rd_data  output  XLEN  register file write data.
- o_pending  output  32  bit n set while an entry with rd=n sits in the FIFO; bit 0 always 0.
- o_fifo_full  output  1  FIFO holds FIFO_DEPTH entries.

Behaviour:
- Reset (async, immediate):
  - o_rd=0, o_rd_data=0.
  - FIFO emptied (pointers and count 0), o_pending=0, o_fifo_full=0.
  - Round-robin pointer set to favour load.
- o_rd/o_rd_data are registered. Each posedge loads exactly one of:
  - ALU: if i_alu_valid, load {i_alu_rd, i_alu_data}. ALU latency is 1 cycle.
  - FIFO head: else if FIFO non-empty, load the head and pop it.
  - Idle: else load o_rd=0. o_rd_data holds its previous value.
- ALU wins every cycle it is valid. FIFO entries wait with no starvation guard; the ALU stream is the pipeline's responsibility.
- Acceptance (one FIFO push per cycle maximum):
  - Ready is asserted only to the granted source and only while FIFO count < FIFO_DEPTH.
  - Ready is never asserted when full, even if a pop happens the same cycle.
- Grant:
  - If only one source is valid, it is granted.
  - If both are valid, the round-robin pointer decides. The pointer flips after each accepted transfer made while both were valid.
- Ready depends on the other source's valid and on full, not on its own valid.
- rd=0 results:
  - Accepted load/muldiv with rd=0: handshake completes, nothing is pushed, o_pending unchanged.
  - ALU with rd=0: o_rd=0.
- Push and pop in the same cycle are allowed when not full; count is unchanged.
- Minimum load/muldiv latency is 2 cycles (accept edge → FIFO, next edge → o_rd).
- FIFO preserves acceptance order. Pointers wrap modulo FIFO_DEPTH.
- o_pending is the combinational OR over valid FIFO entries of the one-hot rd.
  - A popped entry's bit clears in the same cycle its value appears on o_rd.
  - The bit stays set if another valid entry has the same rd.
- Register file semantics for o_rd=0: no write.

Optional Feature:
- Macro WB_PERF_EN.
- Defined: adds output o_blocked_cycles [31:0].
  - Counts cycles in which the FIFO is non-empty and i_alu_valid=1.
  - Reset 0, wraps at 2^32.
- Not defined: port and counter are absent; no other behavioural difference.

Test Plan:
1. Reset mid-operation:
   - Stimulus: FIFO holding 3 entries, assert i_reset asynchronously between edges.
   - Required: immediately o_rd=0, o_pending=0, o_fifo_full=0; after release, ld_ready=1.
2. ALU only:
   - Stimulus: alu rd=5 data=0xDEADBEEF.
   - Required: next cycle o_rd=5, o_rd_data=0xDEADBEEF; the following cycle o_rd=0.
3. Load blocked then drained:
   - Stimulus: load rd=7 data=0x11 accepted while ALU valid for 3 consecutive cycles.
   - Required: o_pending[7]=1 during those cycles; o_rd=7/0x11 on the first cycle ALU is idle; o_pending[7]=0 then.
4. Simultaneous load and muldiv:
   - Stimulus: ld rd=3 and md rd=4 both valid from reset.
   - Required: load accepted first, muldiv next cycle; o_rd sequence 3 then 4.
5. Fill FIFO with DEPTH=4:
   - Stimulus: ALU held valid while pushing 4 loads.
   - Required: o_fifo_full=1 and o_ld_ready=0 on the 5th offer; drops after one ALU-idle cycle pops an entry.
6. rd=0 load accepted:
   - Required: no FIFO count change, o_pending=0, o_rd stays 0.
